// File: rtl/wb_uart_master.sv
// UART-driven Wishbone initiator: parses 'R'/'W' byte frames, issues one
// single-beat bus access and returns the read data, 'K' or 'E' over the UART.
module wb_uart_master #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned IDLE_TO = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        STB,
  output logic        WE,
  output logic [31:0] ADDR,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK,
  output logic        busy
);

  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_ER = 8'h45;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned IW = $clog2(IDLE_TO + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(IDLE_TO - 1);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS, SEND} state_t;

  state_t        state;
  logic          op_w;
  logic          single;
  logic [1:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] icnt;
  logic [31:0]   resp;

  assign busy = (state != IDLE);

  // Command parser, bus access and response sequencer in one FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_w     <= 1'b0;
      single   <= 1'b0;
      cnt      <= '0;
      tcnt     <= '0;
      icnt     <= '0;
      resp     <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      STB      <= 1'b0;
      WE       <= 1'b0;
      ADDR     <= '0;
      DAT_O    <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done && (rx_data == CMD_R || rx_data == CMD_W)) begin
            op_w  <= (rx_data == CMD_W);
            cnt   <= '0;
            icnt  <= '0;
            state <= GET_ADDR;
          end
        end
        GET_ADDR, GET_DATA: begin
          if (rx_done) begin
            icnt <= '0;
            if (state == GET_ADDR) ADDR  <= {ADDR[23:0], rx_data};
            else                   DAT_O <= {DAT_O[23:0], rx_data};
            if (cnt == 2'd3) begin
              cnt <= '0;
              if (state == GET_ADDR && op_w) begin
                state <= GET_DATA;
              end else begin
                state <= BUS;
                STB   <= 1'b1;
                WE    <= op_w;
                tcnt  <= '0;
              end
            end else begin
              cnt <= cnt + 2'd1;
            end
          end else if (icnt == I_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        BUS: begin
          // ACK is tested before the timeout so a last-cycle ACK still wins
          if (ACK) begin
            STB      <= 1'b0;
            WE       <= 1'b0;
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= SEND;
            if (op_w) begin
              tx_data <= RSP_OK;
              single  <= 1'b1;
            end else begin
              tx_data <= DAT_I[31:24];
              resp    <= {DAT_I[23:0], 8'h00};
              single  <= 1'b0;
            end
          end else if (tcnt == T_LAST) begin
            STB      <= 1'b0;
            WE       <= 1'b0;
            tx_start <= 1'b1;
            tx_data  <= RSP_ER;
            single   <= 1'b1;
            cnt      <= '0;
            state    <= SEND;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        SEND: begin
          if (tx_done && !tx_start) begin
            if (single || cnt == 2'd3) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt      <= cnt + 2'd1;
              tx_start <= 1'b1;
              tx_data  <= resp[31:24];
              resp     <= {resp[23:0], 8'h00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
